// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller: steps one digit per scan_clk rising edge
// with an all-off guard gap, and commits shadowed display writes only at frame wrap.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        scan_clk,
  input  logic        wr_req,
  input  logic [31:0] wr_data,
  input  logic [7:0]  wr_dp,
  input  logic [7:0]  wr_blank,
  output logic        wr_ack,
  output logic [2:0]  digit_sel,
  output logic [3:0]  nibble,
  output logic        dp,
  output logic [7:0]  an,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, GAP, DRIVE} state_t;

  localparam logic [2:0] LAST_PTR = 3'(NUM_DIGITS - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic        sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
  logic        pending_q, pending_d;
  logic [31:0] shadow_data_q, shadow_data_d, active_data_q, active_data_d;
  logic [7:0]  shadow_dp_q, shadow_dp_d, active_dp_q, active_dp_d;
  logic [7:0]  shadow_blank_q, shadow_blank_d, active_blank_q, active_blank_d;
  logic        wr_ack_q, wr_ack_d, frame_done_q, frame_done_d;
  logic [7:0]  an_q, an_d;
  logic [2:0]  digit_sel_q, digit_sel_d;
  logic [3:0]  nibble_q, nibble_d;
  logic        dp_q, dp_d;
  logic        step, wrap;

  always_comb begin
    sync1_d        = scan_clk;
    sync2_d        = sync1_q;
    hist_d         = sync2_q;
    step           = sync2_q & ~hist_q;
    wrap           = 1'b0;
    state_d        = state_q;
    ptr_d          = ptr_q;
    gap_cnt_d      = gap_cnt_q;
    pending_d      = pending_q;
    shadow_data_d  = shadow_data_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_blank_d = shadow_blank_q;
    active_data_d  = active_data_q;
    active_dp_d    = active_dp_q;
    active_blank_d = active_blank_q;
    wr_ack_d       = 1'b0;

    // Steps arriving during the gap are intentionally dropped.
    case (state_q)
      IDLE: begin
        if (step) begin
          state_d   = GAP;
          gap_cnt_d = 8'd0;
          ptr_d     = 3'd0;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = DRIVE;
          gap_cnt_d = 8'd0;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      DRIVE: begin
        if (step) begin
          state_d   = GAP;
          gap_cnt_d = 8'd0;
          if (ptr_q == LAST_PTR) begin
            ptr_d = 3'd0;
            wrap  = 1'b1;
          end else begin
            ptr_d = ptr_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    frame_done_d = wrap;
    if (wrap && pending_q) begin
      active_data_d  = shadow_data_q;
      active_dp_d    = shadow_dp_q;
      active_blank_d = shadow_blank_q;
      pending_d      = 1'b0;
    end

    // Capture and commit are exclusive: one needs pending clear, the other set.
    if (wr_req && !pending_q) begin
      shadow_data_d  = wr_data;
      shadow_dp_d    = wr_dp;
      shadow_blank_d = wr_blank;
      pending_d      = 1'b1;
      wr_ack_d       = 1'b1;
    end

    an_d = 8'hFF;
    if (state_d == DRIVE && ptr_d <= LAST_PTR && !active_blank_d[ptr_d]) begin
      an_d[ptr_d] = 1'b0;
    end
    digit_sel_d = ptr_q;
    nibble_d    = active_data_q[{ptr_q, 2'b00} +: 4];
    dp_d        = ~active_dp_q[ptr_q];
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q        <= IDLE;
      ptr_q          <= 3'd0;
      gap_cnt_q      <= 8'd0;
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      hist_q         <= 1'b0;
      pending_q      <= 1'b0;
      shadow_data_q  <= 32'd0;
      shadow_dp_q    <= 8'd0;
      shadow_blank_q <= 8'd0;
      active_data_q  <= 32'd0;
      active_dp_q    <= 8'd0;
      active_blank_q <= 8'hFF;
      wr_ack_q       <= 1'b0;
      frame_done_q   <= 1'b0;
      an_q           <= 8'hFF;
      digit_sel_q    <= 3'd0;
      nibble_q       <= 4'd0;
      dp_q           <= 1'b1;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      gap_cnt_q      <= gap_cnt_d;
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      hist_q         <= hist_d;
      pending_q      <= pending_d;
      shadow_data_q  <= shadow_data_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_blank_q <= shadow_blank_d;
      active_data_q  <= active_data_d;
      active_dp_q    <= active_dp_d;
      active_blank_q <= active_blank_d;
      wr_ack_q       <= wr_ack_d;
      frame_done_q   <= frame_done_d;
      an_q           <= an_d;
      digit_sel_q    <= digit_sel_d;
      nibble_q       <= nibble_d;
      dp_q           <= dp_d;
    end
  end

  assign wr_ack     = wr_ack_q;
  assign frame_done = frame_done_q;
  assign an         = an_q;
  assign digit_sel  = digit_sel_q;
  assign nibble     = nibble_q;
  assign dp         = dp_q;

endmodule
